// File: rtl/mbssoc_mem_arbiter.sv
// Two-core round-robin RAM arbiter with bounded hold under contention.
// Optional MBSSOC_ARB_LOCK_EN: an owner asserting lock is never preempted.
module mbssoc_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            core_re,
  input  logic [1:0]            core_we,
  input  logic [ADDR_WIDTH-1:0] addr_bus0,
  input  logic [ADDR_WIDTH-1:0] addr_bus1,
  input  logic [1:0]            lock,
  output logic [1:0]            grant,
  output logic [1:0]            cpu_pause,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  cpu_sel
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic       rr_reg, rr_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic       cpu_sel_reg, cpu_sel_next;

  logic [1:0] req;
  logic       owner_valid, own_idx, own_req, oth_req, owner_lock, mux_sel;
  state_t     other_state;

  assign req         = core_re | core_we;
  assign owner_valid = (state_reg == OWN0) || (state_reg == OWN1);
  assign own_idx     = (state_reg == OWN1);
  assign own_req     = req[own_idx];
  assign oth_req     = req[~own_idx];
  assign other_state = own_idx ? OWN0 : OWN1;

`ifdef MBSSOC_ARB_LOCK_EN
  // Only the current owner's lock matters; a bystander's lock is ignored.
  assign owner_lock = owner_valid & lock[own_idx];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign owner_lock  = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req == 2'b11)  state_next = rr_reg ? OWN1 : OWN0;
        else if (req[0])   state_next = OWN0;
        else if (req[1])   state_next = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req)
          state_next = oth_req ? other_state : IDLE;
        else if (oth_req && !owner_lock && hold_cnt_reg >= HOLD_LIMIT)
          state_next = other_state;
      end
      default: state_next = IDLE;
    endcase
  end

  // hold_cnt counts consecutive contested cycles of the current tenure.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (!owner_valid || state_next != state_reg || !oth_req)
      hold_cnt_next = 8'd0;
    else if (!owner_lock && hold_cnt_reg != 8'hFF)
      hold_cnt_next = hold_cnt_reg + 8'd1;
  end

  always_comb begin
    rr_next      = rr_reg;
    cpu_sel_next = cpu_sel_reg;
    if (state_next == OWN0 && state_reg != OWN0) begin
      rr_next      = 1'b1;
      cpu_sel_next = 1'b0;
    end else if (state_next == OWN1 && state_reg != OWN1) begin
      rr_next      = 1'b0;
      cpu_sel_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_reg       <= 1'b0;
      hold_cnt_reg <= 8'd0;
      cpu_sel_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_reg       <= rr_next;
      hold_cnt_reg <= hold_cnt_next;
      cpu_sel_reg  <= cpu_sel_next;
    end
  end

  assign grant   = {state_reg == OWN1, state_reg == OWN0};
  assign cpu_sel = cpu_sel_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pause
      assign cpu_pause[gi] = req[gi] & ~grant[gi];
    end
  endgenerate

  // Write wins over read; only the owner's command ever reaches the RAM.
  assign mux_sel  = owner_valid ? own_idx : cpu_sel_reg;
  assign ram_addr = mux_sel ? addr_bus1 : addr_bus0;
  assign ram_we   = owner_valid & core_we[own_idx];
  assign ram_re   = owner_valid & core_re[own_idx] & ~core_we[own_idx];

endmodule

// File: tb/tb_mbssoc_mem_arbiter.sv
// Self-checking bench for mbssoc_mem_arbiter: directed vector table, hold/lock
// sequences and randomized traffic against a tenure-based reference model.
module tb_mbssoc_mem_arbiter;
  localparam int AW = 32;
  localparam int MH = 4;
  localparam logic [AW-1:0] A0 = 32'h0000_0100;
  localparam logic [AW-1:0] A1 = 32'h0000_0040;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    core_re, core_we, lock;
  logic [AW-1:0] addr_bus0, addr_bus1;
  logic [1:0]    grant, cpu_pause;
  logic          ram_re, ram_we, cpu_sel;
  logic [AW-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  mbssoc_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .core_re(core_re), .core_we(core_we),
    .addr_bus0(addr_bus0), .addr_bus1(addr_bus1), .lock(lock),
    .grant(grant), .cpu_pause(cpu_pause), .ram_re(ram_re), .ram_we(ram_we),
    .ram_addr(ram_addr), .cpu_sel(cpu_sel)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the RAM, how long the current tenure has been
  // contested, whose turn it is on a tie, and who owned last.
  int m_owner = -1;
  int m_cont  = 0;
  int m_turn  = 0;
  int m_last  = 0;

  function automatic logic [38:0] model_out();
    logic [1:0] req, g, p;
    logic r, w;
    logic [AW-1:0] a;
    req = core_re | core_we;
    g = 2'b00; r = 1'b0; w = 1'b0;
    if (m_owner >= 0) begin
      g = 2'b01 << m_owner;
      w = core_we[m_owner];
      r = core_re[m_owner] && !core_we[m_owner];
      a = (m_owner == 1) ? addr_bus1 : addr_bus0;
    end else begin
      a = (m_last == 1) ? addr_bus1 : addr_bus0;
    end
    p = req & ~g;
    return {g, p, r, w, 1'(m_last), a};
  endfunction

  task automatic model_step();
    logic [1:0] req;
    int nxt, j;
    bit held;
    req = core_re | core_we;
    if (rst) begin
      m_owner = -1; m_cont = 0; m_turn = 0; m_last = 0;
      return;
    end
    nxt = m_owner;
    held = 0;
    if (m_owner < 0) begin
      if (req == 2'b11)  nxt = m_turn;
      else if (req[0])   nxt = 0;
      else if (req[1])   nxt = 1;
    end else begin
      j = 1 - m_owner;
`ifdef MBSSOC_ARB_LOCK_EN
      held = lock[m_owner];
`endif
      if (!req[m_owner])                      nxt = req[j] ? j : -1;
      else if (req[j] && !held && m_cont + 1 >= MH) nxt = j;
    end
    if (nxt != m_owner || nxt < 0 || !req[1 - nxt]) m_cont = 0;
    else if (!held && m_cont < 255)                 m_cont = m_cont + 1;
    if (nxt >= 0 && nxt != m_owner) begin
      m_turn = 1 - nxt;
      m_last = nxt;
    end
    m_owner = nxt;
  endtask

  function automatic logic [38:0] dut_out();
    return {grant, cpu_pause, ram_re, ram_we, cpu_sel, ram_addr};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (grant,pause,re,we,sel,addr)", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] re, input logic [1:0] we,
                       input logic [1:0] lk);
    rst = r; core_re = re; core_we = we; lock = lk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] re, we;
    logic [1:0] grant, pause;
    logic       rre, rwe, sel;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [38:0] exp;
    logic [1:0]  g;
    int          k;
    // Outputs are those seen during the cycle, before the following edge.
    vecs[0]  = '{0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0};
    vecs[1]  = '{0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 0};
    vecs[2]  = '{0, 2'b01, 2'b00, 2'b01, 2'b00, 1, 0, 0};
    vecs[3]  = '{0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0};
    vecs[4]  = '{1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0};
    vecs[5]  = '{0, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, 0};
    vecs[6]  = '{0, 2'b11, 2'b00, 2'b01, 2'b10, 1, 0, 0};
    vecs[7]  = '{0, 2'b10, 2'b00, 2'b01, 2'b10, 0, 0, 0};
    vecs[8]  = '{0, 2'b10, 2'b00, 2'b10, 2'b00, 1, 0, 1};
    vecs[9]  = '{0, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 1};
    vecs[10] = '{0, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, 1};
    vecs[11] = '{0, 2'b11, 2'b00, 2'b01, 2'b10, 1, 0, 0};
    vecs[12] = '{0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0};
    vecs[13] = '{0, 2'b10, 2'b10, 2'b00, 2'b10, 0, 0, 0};
    vecs[14] = '{0, 2'b10, 2'b10, 2'b10, 2'b00, 0, 1, 1};
    vecs[15] = '{1, 2'b10, 2'b10, 2'b10, 2'b00, 0, 1, 1};
    vecs[16] = '{0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0};

    addr_bus0 = A0; addr_bus1 = A1;
    @(negedge clk);
    apply(1, 2'b00, 2'b00, 2'b00);
    tick();
    tick();

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst, vecs[i].re, vecs[i].we, 2'b00);
      exp = {vecs[i].grant, vecs[i].pause, vecs[i].rre, vecs[i].rwe, vecs[i].sel,
             vecs[i].sel ? A1 : A0};
      check($sformatf("vec%0d", i), dut_out(), exp);
      tick();
    end

    // Continuous contention: ownership alternates every MH cycles.
    apply(1, 2'b00, 2'b00, 2'b00);
    tick();
    apply(0, 2'b11, 2'b00, 2'b00);
    check("hold_idle", {grant, cpu_pause}, 4'b0011);
    tick();
    for (int c = 0; c < 6 * MH; c++) begin
      apply(0, 2'b11, 2'b00, 2'b00);
      g = (((c / MH) % 2) == 0) ? 2'b01 : 2'b10;
      check($sformatf("hold_c%0d", c), {grant, cpu_pause}, {g, ~g});
      tick();
    end

    // Owner 0 asserts lock for 20 contested cycles, then releases it.
    apply(1, 2'b00, 2'b00, 2'b00);
    tick();
    apply(0, 2'b11, 2'b00, 2'b01);
    tick();
    for (int c = 0; c < 20 + 2 * MH; c++) begin
      apply(0, 2'b11, 2'b00, (c < 20) ? 2'b01 : 2'b00);
`ifdef MBSSOC_ARB_LOCK_EN
      k = (c < 20) ? 0 : c - 20;
`else
      k = c;
`endif
      g = (((k / MH) % 2) == 0) ? 2'b01 : 2'b10;
      check($sformatf("lock_c%0d", c), {grant, cpu_pause}, {g, ~g});
      tick();
    end

    // Randomized traffic against the reference model.
    apply(1, 2'b00, 2'b00, 2'b00);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] re, we;
      if ($urandom_range(3) == 0) begin
        re = 2'($urandom); we = 2'($urandom);
      end else begin
        re = core_re; we = core_we;
      end
      addr_bus0 = $urandom; addr_bus1 = $urandom;
      apply($urandom_range(59) == 0, re, we, 2'($urandom));
      check($sformatf("rand_c%0d", c), dut_out(), model_out());
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
